// File: rtl/ysyx_bus_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ysyx_bus_pkg : shared types and constants for the bus arbiter   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package ysyx_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LSU  = 2'd2
  } owner_e;

  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;
  localparam logic [1:0] c_RESP_DECERR = 2'b11;

  localparam logic [2:0] c_SIZE_BYTE = 3'b000;
  localparam logic [2:0] c_SIZE_HALF = 3'b001;
  localparam logic [2:0] c_SIZE_WORD = 3'b010;

  // Unrecognised strobe patterns fall back to a full word access.
  function automatic logic [2:0] strb_to_size(input logic [7:0] strb);
    logic [2:0] size;
    case (strb)
      8'h01:   size = c_SIZE_BYTE;
      8'h03:   size = c_SIZE_HALF;
      default: size = c_SIZE_WORD;
    endcase
    return size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_bus_arb_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ysyx_bus_arb_if : IFU/LSU request side plus AXI4-lite master    |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface ysyx_bus_arb_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] ifu_araddr;
  logic            ifu_arvalid;
  logic [XLEN-1:0] ifu_rdata;
  logic            ifu_rvalid;

  logic [XLEN-1:0] lsu_araddr;
  logic            lsu_arvalid;
  logic [7:0]      lsu_rstrb;
  logic [XLEN-1:0] lsu_rdata;
  logic            lsu_rvalid;
  logic [XLEN-1:0] lsu_awaddr;
  logic            lsu_awvalid;
  logic [XLEN-1:0] lsu_wdata;
  logic [7:0]      lsu_wstrb;
  logic            lsu_wvalid;
  logic            lsu_wready;
  logic            bus_err;

  logic [XLEN-1:0] m_araddr;
  logic [2:0]      m_arsize;
  logic            m_arvalid;
  logic            m_arready;
  logic [XLEN-1:0] m_rdata;
  logic [1:0]      m_rresp;
  logic            m_rvalid;
  logic            m_rready;
  logic [XLEN-1:0] m_awaddr;
  logic [2:0]      m_awsize;
  logic            m_awvalid;
  logic            m_awready;
  logic [XLEN-1:0] m_wdata;
  logic [3:0]      m_wstrb;
  logic            m_wvalid;
  logic            m_wready;
  logic [1:0]      m_bresp;
  logic            m_bvalid;
  logic            m_bready;

  modport master (
    input  ifu_araddr, ifu_arvalid,
    output ifu_rdata, ifu_rvalid,
    input  lsu_araddr, lsu_arvalid, lsu_rstrb,
    output lsu_rdata, lsu_rvalid,
    input  lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid,
    output lsu_wready, bus_err,
    output m_araddr, m_arsize, m_arvalid, input m_arready,
    input  m_rdata, m_rresp, m_rvalid, output m_rready,
    output m_awaddr, m_awsize, m_awvalid, input m_awready,
    output m_wdata, m_wstrb, m_wvalid, input m_wready,
    input  m_bresp, m_bvalid, output m_bready
  );

  modport slave (
    output ifu_araddr, ifu_arvalid,
    input  ifu_rdata, ifu_rvalid,
    output lsu_araddr, lsu_arvalid, lsu_rstrb,
    input  lsu_rdata, lsu_rvalid,
    output lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid,
    input  lsu_wready, bus_err,
    input  m_araddr, m_arsize, m_arvalid, output m_arready,
    output m_rdata, m_rresp, m_rvalid, input m_rready,
    input  m_awaddr, m_awsize, m_awvalid, output m_awready,
    input  m_wdata, m_wstrb, m_wvalid, output m_wready,
    output m_bresp, m_bvalid, input m_bready
  );

endinterface
`default_nettype wire

// File: rtl/ysyx_bus_strb_align.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ysyx_bus_strb_align : strobe-to-size encode and store lane shift |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module ysyx_bus_strb_align
  import ysyx_bus_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [7:0]      i_strb,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_wdata,
  output logic [2:0]      o_size,
  output logic [3:0]      o_wstrb,
  output logic [XLEN-1:0] o_wdata
);

  assign o_size  = strb_to_size(i_strb);
  // Lanes shifted past the top of the bus are dropped, not wrapped.
  assign o_wstrb = i_strb[3:0] << i_addr_lo;
  assign o_wdata = i_wdata << {i_addr_lo, 3'b000};

endmodule
`default_nettype wire

// File: rtl/ysyx_bus_arb.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ysyx_bus_arb : IFU/LSU arbiter onto one AXI4-lite master port   |
// | Optional round-robin IFU/LSU grant: YSYX_BUS_ARB_RR_EN  Rev 1.0 |
// +-----------------------------------------------------------------+
module ysyx_bus_arb
  import ysyx_bus_pkg::*;
#(
  parameter int         XLEN     = 32,
  parameter logic [2:0] IFU_SIZE = 3'b010
) (
  input  logic           clock,
  input  logic           reset,
  ysyx_bus_arb_if.master bus
);

  state_e          r_state;
  owner_e          r_owner;
  logic            r_aw_done;
  logic            r_w_done;
  logic [XLEN-1:0] r_araddr;
  logic [2:0]      r_arsize;
  logic            r_arvalid;
  logic            r_rready;
  logic [XLEN-1:0] r_awaddr;
  logic [2:0]      r_awsize;
  logic            r_awvalid;
  logic [XLEN-1:0] r_wdata;
  logic [3:0]      r_wstrb;
  logic            r_wvalid;
  logic            r_bready;
  logic [XLEN-1:0] r_rdata;
  logic            r_ifu_rvalid;
  logic            r_lsu_rvalid;
  logic            r_lsu_wready;
  logic            r_bus_err;
`ifdef YSYX_BUS_ARB_RR_EN
  owner_e          r_last_owner;
`endif

  logic            w_store_req;
  logic            w_lsu_req;
  logic            w_pick_lsu;
  logic            w_pick_ifu;
  logic            w_aw_fin;
  logic            w_w_fin;
  logic [7:0]      w_sel_strb;
  logic [2:0]      w_size;
  logic [3:0]      w_wstrb;
  logic [XLEN-1:0] w_wdata;

  always_comb begin
    w_store_req = bus.lsu_awvalid && bus.lsu_wvalid;
    w_lsu_req   = w_store_req || bus.lsu_arvalid;
`ifdef YSYX_BUS_ARB_RR_EN
    w_pick_lsu  = w_lsu_req && !(bus.ifu_arvalid && (r_last_owner == OWN_LSU));
`else
    w_pick_lsu  = w_lsu_req;
`endif
    w_pick_ifu  = bus.ifu_arvalid && !w_pick_lsu;
    w_sel_strb  = w_store_req ? bus.lsu_wstrb : bus.lsu_rstrb;
    w_aw_fin    = r_aw_done || (r_awvalid && bus.m_awready);
    w_w_fin     = r_w_done || (r_wvalid && bus.m_wready);
  end

  ysyx_bus_strb_align #(
    .XLEN (XLEN)
  ) u_align (
    .i_strb    (w_sel_strb),
    .i_addr_lo (bus.lsu_awaddr[1:0]),
    .i_wdata   (bus.lsu_wdata),
    .o_size    (w_size),
    .o_wstrb   (w_wstrb),
    .o_wdata   (w_wdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_NONE;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_araddr     <= '0;
      r_arsize     <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awaddr     <= '0;
      r_awsize     <= '0;
      r_awvalid    <= 1'b0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_rdata      <= '0;
      r_ifu_rvalid <= 1'b0;
      r_lsu_rvalid <= 1'b0;
      r_lsu_wready <= 1'b0;
      r_bus_err    <= 1'b0;
`ifdef YSYX_BUS_ARB_RR_EN
      r_last_owner <= OWN_NONE;
`endif
    end else begin
      r_ifu_rvalid <= 1'b0;
      r_lsu_rvalid <= 1'b0;
      r_lsu_wready <= 1'b0;
      r_bus_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_lsu && w_store_req) begin
            r_owner   <= OWN_LSU;
            r_awaddr  <= bus.lsu_awaddr;
            r_awsize  <= w_size;
            r_wstrb   <= w_wstrb;
            r_wdata   <= w_wdata;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= ST_WR_REQ;
`ifdef YSYX_BUS_ARB_RR_EN
            r_last_owner <= OWN_LSU;
`endif
          end else if (w_pick_lsu) begin
            r_owner   <= OWN_LSU;
            r_araddr  <= bus.lsu_araddr;
            r_arsize  <= w_size;
            r_arvalid <= 1'b1;
            r_state   <= ST_RD_ADDR;
`ifdef YSYX_BUS_ARB_RR_EN
            r_last_owner <= OWN_LSU;
`endif
          end else if (w_pick_ifu) begin
            r_owner   <= OWN_IFU;
            r_araddr  <= bus.ifu_araddr;
            r_arsize  <= IFU_SIZE;
            r_arvalid <= 1'b1;
            r_state   <= ST_RD_ADDR;
`ifdef YSYX_BUS_ARB_RR_EN
            r_last_owner <= OWN_IFU;
`endif
          end
        end
        ST_RD_ADDR: begin
          if (bus.m_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          // Response pulses are registered here so they appear in the DONE cycle.
          if (bus.m_rvalid) begin
            r_rready     <= 1'b0;
            r_rdata      <= bus.m_rdata;
            r_ifu_rvalid <= (r_owner == OWN_IFU);
            r_lsu_rvalid <= (r_owner == OWN_LSU);
            r_bus_err    <= (bus.m_rresp != c_RESP_OKAY);
            r_state      <= ST_DONE;
          end
        end
        ST_WR_REQ: begin
          if (bus.m_awready) r_awvalid <= 1'b0;
          if (bus.m_wready)  r_wvalid  <= 1'b0;
          r_aw_done <= w_aw_fin;
          r_w_done  <= w_w_fin;
          if (w_aw_fin && w_w_fin) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (bus.m_bvalid) begin
            r_bready     <= 1'b0;
            r_lsu_wready <= 1'b1;
            r_bus_err    <= (bus.m_bresp != c_RESP_OKAY);
            r_state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_owner <= OWN_NONE;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ifu_rdata  = r_rdata;
  assign bus.ifu_rvalid = r_ifu_rvalid;
  assign bus.lsu_rdata  = r_rdata;
  assign bus.lsu_rvalid = r_lsu_rvalid;
  assign bus.lsu_wready = r_lsu_wready;
  assign bus.bus_err    = r_bus_err;
  assign bus.m_araddr   = r_araddr;
  assign bus.m_arsize   = r_arsize;
  assign bus.m_arvalid  = r_arvalid;
  assign bus.m_rready   = r_rready;
  assign bus.m_awaddr   = r_awaddr;
  assign bus.m_awsize   = r_awsize;
  assign bus.m_awvalid  = r_awvalid;
  assign bus.m_wdata    = r_wdata;
  assign bus.m_wstrb    = r_wstrb;
  assign bus.m_wvalid   = r_wvalid;
  assign bus.m_bready   = r_bready;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_bus_arb.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_ysyx_bus_arb : directed scoreboard bench for ysyx_bus_arb    |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_ysyx_bus_arb;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ysyx_bus_arb_if #(.XLEN(32)) bif ();

  ysyx_bus_arb #(
    .XLEN     (32),
    .IFU_SIZE (3'b010)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif.master)
  );

  int          n_vec   = 0;
  int          n_err   = 0;
  int          n_pulse = 0;
  int          n_awv   = 0;
  int          n_wv    = 0;
  int          n_brdy  = 0;
  exp_t        sb[$];
  logic [31:0] s_araddr;
  logic [31:0] snap_araddr = '0;
  logic [2:0]  snap_arsize = '0;
  logic [31:0] snap_awaddr = '0;
  logic [2:0]  snap_awsize = '0;
  logic [31:0] snap_wdata  = '0;
  logic [3:0]  snap_wstrb  = '0;
  int          r_dly     = 0;
  int          aw_dly    = 0;
  int          w_dly     = 0;
  logic [1:0]  rresp_cfg = 2'b00;
  logic [1:0]  bresp_cfg = 2'b00;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'hDEAD_BEEF);
  endfunction

  function automatic exp_t mk(input logic [1:0] kind, input logic [31:0] data, input logic err);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.err  = err;
    return e;
  endfunction

  // AXI slave: fixed read contents, per-channel programmable ready/valid delay.
  initial begin : slave
    int rc, ac, wc;
    rc = 0; ac = 0; wc = 0; s_araddr = '0;
    bif.m_arready = 1'b1; bif.m_rvalid = 1'b0; bif.m_rdata = '0; bif.m_rresp = '0;
    bif.m_awready = 1'b0; bif.m_wready = 1'b0; bif.m_bvalid = 1'b0; bif.m_bresp = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        rc = 0; ac = 0; wc = 0;
        bif.m_rvalid = 1'b0; bif.m_awready = 1'b0; bif.m_wready = 1'b0; bif.m_bvalid = 1'b0;
      end else begin
        if (bif.m_arvalid) s_araddr = bif.m_araddr;
        if (bif.m_rready) begin
          rc++;
          bif.m_rvalid = (rc > r_dly);
          bif.m_rdata  = mem_rd(s_araddr);
          bif.m_rresp  = rresp_cfg;
        end else begin
          rc = 0; bif.m_rvalid = 1'b0;
        end
        if (bif.m_awvalid) begin ac++; bif.m_awready = (ac > aw_dly); end
        else begin ac = 0; bif.m_awready = 1'b0; end
        if (bif.m_wvalid) begin wc++; bif.m_wready = (wc > w_dly); end
        else begin wc = 0; bif.m_wready = 1'b0; end
        bif.m_bvalid = bif.m_bready;
        bif.m_bresp  = bresp_cfg;
      end
    end
  end

  always @(negedge clock) begin : mon
    exp_t        e;
    logic [1:0]  kind;
    logic [31:0] rd;
    if (reset) begin
      if (bif.m_arvalid) begin snap_araddr = bif.m_araddr; snap_arsize = bif.m_arsize; end
      if (bif.m_awvalid) begin n_awv++; snap_awaddr = bif.m_awaddr; snap_awsize = bif.m_awsize; end
      if (bif.m_wvalid)  begin n_wv++;  snap_wdata = bif.m_wdata;   snap_wstrb = bif.m_wstrb;   end
      if (bif.m_bready)  n_brdy++;
      if (bif.ifu_rvalid || bif.lsu_rvalid || bif.lsu_wready) begin
        n_pulse++;
        kind = bif.lsu_wready ? 2'd3 : (bif.lsu_rvalid ? 2'd2 : 2'd1);
        rd   = bif.lsu_rvalid ? bif.lsu_rdata : bif.ifu_rdata;
        check("pulse_onehot", 64'($countones({bif.ifu_rvalid, bif.lsu_rvalid, bif.lsu_wready})), 64'd1);
        if (sb.size() == 0) begin
          check("unexpected_pulse", 64'(kind), 64'd0);
        end else begin
          e = sb.pop_front();
          check("resp_owner", 64'(kind), 64'(e.kind));
          if (kind != 2'd3) check("resp_rdata", 64'(rd), 64'(e.data));
          check("resp_bus_err", 64'(bif.bus_err), 64'(e.err));
        end
      end else if (bif.bus_err) begin
        check("stray_bus_err", 64'(bif.bus_err), 64'd0);
      end
    end
  end

  function automatic logic pulse_of(input int which);
    case (which)
      0:       return bif.ifu_rvalid;
      1:       return bif.lsu_rvalid;
      default: return bif.lsu_wready;
    endcase
  endfunction

  task automatic wait_pulse(input int which, input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!pulse_of(which) && cyc < 60);
    check(tag, 64'(pulse_of(which)), 64'd1);
  endtask

  task automatic do_fetch(input logic [31:0] addr, input string tag);
    int cyc;
    bif.ifu_araddr  = addr;
    bif.ifu_arvalid = 1'b1;
    sb.push_back(mk(2'd1, mem_rd(addr), 1'b0));
    wait_pulse(0, {tag, "_done"}, cyc);
    bif.ifu_arvalid = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'd3);
    check({tag, "_araddr"}, 64'(snap_araddr), 64'(addr));
    check({tag, "_arsize"}, 64'(snap_arsize), 64'd2);
    @(negedge clock);
    check({tag, "_pulse_width"}, 64'(bif.ifu_rvalid), 64'd0);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [7:0] strb,
                         input logic [2:0] size, input logic err, input string tag);
    int cyc;
    bif.lsu_araddr  = addr;
    bif.lsu_rstrb   = strb;
    bif.lsu_arvalid = 1'b1;
    sb.push_back(mk(2'd2, mem_rd(addr), err));
    wait_pulse(1, {tag, "_done"}, cyc);
    bif.lsu_arvalid = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'd3);
    check({tag, "_araddr"}, 64'(snap_araddr), 64'(addr));
    check({tag, "_arsize"}, 64'(snap_arsize), 64'(size));
    @(negedge clock);
    check({tag, "_pulse_width"}, 64'(bif.lsu_rvalid), 64'd0);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] strb,
                          input logic [3:0] exp_strb, input logic [31:0] exp_data, input logic [2:0] size,
                          input int exp_aw, input int exp_w, input logic err, input string tag);
    int cyc, a0, w0, b0, lat;
    a0 = n_awv; w0 = n_wv; b0 = n_brdy;
    lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly);
    bif.lsu_awaddr  = addr;
    bif.lsu_wdata   = data;
    bif.lsu_wstrb   = strb;
    bif.lsu_awvalid = 1'b1;
    bif.lsu_wvalid  = 1'b1;
    sb.push_back(mk(2'd3, 32'h0, err));
    wait_pulse(2, {tag, "_done"}, cyc);
    bif.lsu_awvalid = 1'b0;
    bif.lsu_wvalid  = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_awaddr"}, 64'(snap_awaddr), 64'(addr));
    check({tag, "_awsize"}, 64'(snap_awsize), 64'(size));
    check({tag, "_wstrb"}, 64'(snap_wstrb), 64'(exp_strb));
    check({tag, "_wdata"}, 64'(snap_wdata), 64'(exp_data));
    check({tag, "_awvalid_cycles"}, 64'(n_awv - a0), 64'(exp_aw));
    check({tag, "_wvalid_cycles"}, 64'(n_wv - w0), 64'(exp_w));
    check({tag, "_bready_cycles"}, 64'(n_brdy - b0), 64'd1);
    @(negedge clock);
    check({tag, "_pulse_width"}, 64'(bif.lsu_wready), 64'd0);
  endtask

  initial begin : main
    logic gi, gl;
    int   k, p0;
    bif.ifu_araddr = '0; bif.ifu_arvalid = 1'b0;
    bif.lsu_araddr = '0; bif.lsu_arvalid = 1'b0; bif.lsu_rstrb = 8'h0f;
    bif.lsu_awaddr = '0; bif.lsu_awvalid = 1'b0; bif.lsu_wdata = '0;
    bif.lsu_wstrb  = 8'h0f; bif.lsu_wvalid = 1'b0;

    repeat (2) @(negedge clock);
    check("rst_ifu_rvalid", 64'(bif.ifu_rvalid), 64'd0);
    check("rst_lsu_rvalid", 64'(bif.lsu_rvalid), 64'd0);
    check("rst_lsu_wready", 64'(bif.lsu_wready), 64'd0);
    check("rst_bus_err",    64'(bif.bus_err),    64'd0);
    check("rst_m_arvalid",  64'(bif.m_arvalid),  64'd0);
    check("rst_m_awvalid",  64'(bif.m_awvalid),  64'd0);
    check("rst_m_wvalid",   64'(bif.m_wvalid),   64'd0);
    check("rst_m_rready",   64'(bif.m_rready),   64'd0);
    check("rst_m_bready",   64'(bif.m_bready),   64'd0);
    check("rst_m_araddr",   64'(bif.m_araddr),   64'd0);
    check("rst_m_wdata",    64'(bif.m_wdata),    64'd0);
    check("rst_ifu_rdata",  64'(bif.ifu_rdata),  64'd0);
    reset = 1'b1;
    @(negedge clock);

    do_fetch(32'h8000_0000, "fetch");
    do_load(32'h8000_0010, 8'h0f, 3'd2, 1'b0, "ld_word");
    do_load(32'h8000_0021, 8'h01, 3'd0, 1'b0, "ld_byte");
    do_load(32'h8000_0032, 8'h03, 3'd1, 1'b0, "ld_half");

    // Collision with the LSU as the last owner.
    bif.ifu_araddr = 32'h8000_0100; bif.ifu_arvalid = 1'b1;
    bif.lsu_araddr = 32'h8000_0200; bif.lsu_rstrb = 8'h0f; bif.lsu_arvalid = 1'b1;
`ifdef YSYX_BUS_ARB_RR_EN
    sb.push_back(mk(2'd1, mem_rd(32'h8000_0100), 1'b0));
    sb.push_back(mk(2'd2, mem_rd(32'h8000_0200), 1'b0));
`else
    sb.push_back(mk(2'd2, mem_rd(32'h8000_0200), 1'b0));
    sb.push_back(mk(2'd1, mem_rd(32'h8000_0100), 1'b0));
`endif
    gi = 1'b0; gl = 1'b0; k = 0;
    while (!(gi && gl) && k < 40) begin
      @(negedge clock);
      k++;
      if (bif.lsu_rvalid) begin gl = 1'b1; bif.lsu_arvalid = 1'b0; end
      if (bif.ifu_rvalid) begin gi = 1'b1; bif.ifu_arvalid = 1'b0; end
    end
    check("coll_ifu_served", 64'(gi), 64'd1);
    check("coll_lsu_served", 64'(gl), 64'd1);
    @(negedge clock);

    do_store(32'h8000_0003, 32'h0000_00ab, 8'h01, 4'b1000, 32'hab00_0000, 3'd0, 1, 1, 1'b0, "st_sb");
    do_store(32'h8000_0002, 32'h0000_1234, 8'h03, 4'b1100, 32'h1234_0000, 3'd1, 1, 1, 1'b0, "st_sh");
    do_store(32'h8000_0008, 32'h0055_6677, 8'h07, 4'b0111, 32'h0055_6677, 3'd2, 1, 1, 1'b0, "st_odd_strb");
    do_store(32'h8000_0001, 32'h1122_3344, 8'h0f, 4'b1110, 32'h2233_4400, 3'd2, 1, 1, 1'b0, "st_trunc");

    aw_dly = 2;
    do_store(32'h8000_0040, 32'hcafe_f00d, 8'h0f, 4'b1111, 32'hcafe_f00d, 3'd2, 3, 1, 1'b0, "st_aw_late");
    aw_dly = 0; w_dly = 2;
    do_store(32'h8000_0044, 32'h0bad_beef, 8'h0f, 4'b1111, 32'h0bad_beef, 3'd2, 1, 3, 1'b0, "st_w_late");
    w_dly = 0;

    rresp_cfg = 2'b11;
    do_load(32'h8000_0050, 8'h0f, 3'd2, 1'b1, "ld_err");
    rresp_cfg = 2'b00;
    do_load(32'h8000_0054, 8'h0f, 3'd2, 1'b0, "ld_after_err");
    bresp_cfg = 2'b10;
    do_store(32'h8000_0058, 32'h0000_0001, 8'h0f, 4'b1111, 32'h0000_0001, 3'd2, 1, 1, 1'b1, "st_err");
    bresp_cfg = 2'b00;

    // Reset while the read data phase is stalled.
    r_dly = 6;
    bif.lsu_araddr = 32'h8000_0300; bif.lsu_rstrb = 8'h0f; bif.lsu_arvalid = 1'b1;
    sb.push_back(mk(2'd2, mem_rd(32'h8000_0300), 1'b0));
    k = 0;
    while (!bif.m_rready && k < 20) begin
      @(negedge clock);
      k++;
    end
    check("rst_mid_in_rd_data", 64'(bif.m_rready), 64'd1);
    reset = 1'b0;
    #1;
    check("rst_mid_m_rready",   64'(bif.m_rready),   64'd0);
    check("rst_mid_m_arvalid",  64'(bif.m_arvalid),  64'd0);
    check("rst_mid_lsu_rvalid", 64'(bif.lsu_rvalid), 64'd0);
    check("rst_mid_m_araddr",   64'(bif.m_araddr),   64'd0);
    bif.lsu_arvalid = 1'b0;
    sb.delete();
    p0 = n_pulse;
    @(negedge clock);
    reset = 1'b1;
    r_dly = 0;
    repeat (8) @(negedge clock);
    check("rst_mid_no_pulse", 64'(n_pulse), 64'(p0));
    do_fetch(32'h8000_0080, "fetch_after_rst");

    repeat (3) @(negedge clock);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
